// File: rtl/mem_access_unit.sv
// RV32 data-memory access stage: issues word-aligned cache requests over valid/ready,
// generates store byte lanes and stalls the pipeline until each access completes.
module mem_access_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_func3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [WIDTH-1:0]  ex_wdata,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [3:0]        mem_req_wmask,
  output logic [WIDTH-1:0]  mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [WIDTH-1:0]  mem_resp_data,
  output logic              ld_valid,
  output logic [1:0]        ld_addr_lo,
  output logic [2:0]        ld_func3,
  output logic [WIDTH-1:0]  ld_data,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             op_c;
  logic             bad_c;
  logic             accept_c;
  logic             load_done_c;
  logic [3:0]       wmask_c;
  logic [WIDTH-1:0] wdata_c;
  logic [1:0]       op_lo;
  logic [2:0]       op_f3;

  // Operation decode and alignment/legality check
  assign op_c  = ex_valid & (ex_load | ex_store);
  assign bad_c = (ex_load & ex_store)
               | (ex_func3[1:0] == 2'b11)
               | ((ex_func3[1:0] == 2'b01) & ex_addr[0])
               | ((ex_func3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));

  // Store byte-lane enables and lane-replicated data; loads carry no lanes
  always_comb begin
    wmask_c = 4'b0000;
    wdata_c = '0;
    if (ex_store) begin
      case (ex_func3[1:0])
        2'b00: begin
          wmask_c = 4'b0001 << ex_addr[1:0];
          wdata_c = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          wmask_c = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{ex_wdata[15:0]}};
        end
        default: begin
          wmask_c = 4'b1111;
          wdata_c = ex_wdata;
        end
      endcase
    end
  end

  // Next-state, stall and capture strobes
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    accept_c    = 1'b0;
    load_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_c && !bad_c) begin
          stall     = 1'b1;
          accept_c  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (mem_req_we) begin
            state_nxt = S_IDLE;
          end else begin
            stall     = 1'b1;
            state_nxt = S_WAIT;
          end
        end else begin
          stall = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          load_done_c = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wmask <= 4'b0000;
      mem_req_wdata <= '0;
      op_lo         <= 2'b00;
      op_f3         <= 3'b000;
      ld_valid      <= 1'b0;
      ld_addr_lo    <= 2'b00;
      ld_func3      <= 3'b000;
      ld_data       <= '0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_req_valid <= (state_nxt == S_REQ);
      fault         <= (state == S_IDLE) & op_c & bad_c;
      ld_valid      <= load_done_c;
      // Request fields stay frozen from acceptance until the handshake
      if (accept_c) begin
        mem_req_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
        mem_req_we    <= ex_store;
        mem_req_wmask <= wmask_c;
        mem_req_wdata <= wdata_c;
        op_lo         <= ex_addr[1:0];
        op_f3         <= ex_func3;
      end
      if (load_done_c) begin
        ld_data    <= mem_resp_data;
        ld_addr_lo <= op_lo;
        ld_func3   <= op_f3;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan steps plus randomized
// operations checked against a per-operation cycle/field model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_func3;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        ld_valid;
  logic [1:0]  ld_addr_lo;
  logic [2:0]  ld_func3;
  logic [31:0] ld_data;
  logic        fault;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference copy of the last completed load
  logic [31:0] exp_ld_data;
  logic [1:0]  exp_ld_lo;
  logic [2:0]  exp_ld_f3;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ld_valid(ld_valid), .ld_addr_lo(ld_addr_lo), .ld_func3(ld_func3),
    .ld_data(ld_data), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz = int'(f3[1:0]);
    if (ld && st) return 1'b1;
    if (sz == 3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int bytes = 1 << int'(f3[1:0]);
    if (!st) return 4'b0000;
    return 4'(((1 << bytes) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input bit st, input logic [2:0] f3, input logic [31:0] wd);
    int bytes = 1 << int'(f3[1:0]);
    logic [31:0] r = '0;
    if (!st) return r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((wd >> (8 * (i % bytes))) & 32'hFF);
    return r;
  endfunction

  task automatic check_ld_hold(input string tag);
    chk({tag, ".ld_data"},  ld_data,          exp_ld_data);
    chk({tag, ".ld_lo"},    32'(ld_addr_lo),  32'(exp_ld_lo));
    chk({tag, ".ld_f3"},    32'(ld_func3),    32'(exp_ld_f3));
  endtask

  // Runs one execute-stage instruction; entered just after a falling edge.
  // rd = cycles ready is withheld in REQ, rs = WAIT cycles before the response.
  task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int rd, input int rs, input bit spur);
    bit          is_op = ld | st;
    bit          bad   = m_fault(ld, st, f3, a);
    logic [31:0] e_addr = {a[31:2], 2'b00};
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_func3 = f3; ex_addr = a; ex_wdata = wd;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    if (!is_op || bad) begin
      chk({tag, ".idle_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      ex_valid = 1'b0; mem_resp_valid = spur; mem_resp_data = $urandom;
      #1;
      chk({tag, ".fault"},     32'(fault),         32'(is_op & bad));
      chk({tag, ".no_req"},    32'(mem_req_valid), 32'd0);
      chk({tag, ".stall0"},    32'(stall),         32'd0);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      chk({tag, ".fault_end"}, 32'(fault),         32'd0);
      chk({tag, ".no_ldv"},    32'(ld_valid),      32'd0);
      check_ld_hold(tag);
      return;
    end
    chk({tag, ".accept_stall"}, 32'(stall), 32'd1);
    for (int i = 0; i <= rd; i++) begin
      @(negedge clk);
      mem_req_ready = (i == rd); mem_resp_valid = spur; mem_resp_data = $urandom;
      #1;
      chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, ".req_addr"},  mem_req_addr,        e_addr);
      chk({tag, ".req_we"},    32'(mem_req_we),     32'(st));
      chk({tag, ".req_mask"},  32'(mem_req_wmask),  32'(m_mask(st, f3, a)));
      chk({tag, ".req_wdata"}, mem_req_wdata,       m_wdata(st, f3, wd));
      chk({tag, ".req_stall"}, 32'(stall),          32'((st && i == rd) ? 0 : 1));
      chk({tag, ".req_ldv"},   32'(ld_valid),       32'd0);
    end
    if (st) begin
      @(negedge clk);
      ex_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = spur;
      #1;
      chk({tag, ".st_done_valid"}, 32'(mem_req_valid), 32'd0);
      chk({tag, ".st_done_stall"}, 32'(stall),         32'd0);
      chk({tag, ".st_done_ldv"},   32'(ld_valid),      32'd0);
      check_ld_hold(tag);
      mem_resp_valid = 1'b0;
      return;
    end
    for (int j = 0; j <= rs; j++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_resp_valid = (j == rs);
      mem_resp_data = (j == rs) ? rdat : $urandom;
      #1;
      chk({tag, ".wait_valid"}, 32'(mem_req_valid), 32'd0);
      chk({tag, ".wait_stall"}, 32'(stall),         32'((j == rs) ? 0 : 1));
      chk({tag, ".wait_ldv"},   32'(ld_valid),      32'd0);
    end
    @(negedge clk);
    ex_valid = 1'b0; mem_resp_valid = 1'b0;
    exp_ld_data = rdat; exp_ld_lo = a[1:0]; exp_ld_f3 = f3;
    #1;
    chk({tag, ".ldv_pulse"}, 32'(ld_valid), 32'd1);
    chk({tag, ".ld_stall"},  32'(stall),    32'd0);
    check_ld_hold(tag);
    @(negedge clk);
    #1;
    chk({tag, ".ldv_end"}, 32'(ld_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_func3 = 3'b000;
    ex_addr = '0; ex_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    exp_ld_data = '0; exp_ld_lo = 2'b00; exp_ld_f3 = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.stall",     32'(stall),         32'd0);
    chk("rst.fault",     32'(fault),         32'd0);
    chk("rst.ld_valid",  32'(ld_valid),      32'd0);
    chk("rst.req_addr",  mem_req_addr,       32'd0);
    chk("rst.req_mask",  32'(mem_req_wmask), 32'd0);
    check_ld_hold("rst");

    // Directed plan
    run_op("sb",    1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0, 1'b0);
    run_op("lhu",   1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h8765_4321, 3, 1, 1'b0);
    run_op("lw_mis",1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,         32'h0, 0, 0, 1'b0);
    run_op("f3_11", 1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,         32'h0, 0, 0, 1'b0);
    run_op("ldst",  1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0,         32'h0, 0, 0, 1'b0);
    run_op("sh_mis",1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h1234,      32'h0, 0, 0, 1'b0);
    run_op("sw",    1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
    run_op("lb",    1'b1, 1'b0, 3'b000, 32'h0000_4005, 32'h0,         32'h1122_3344, 0, 0, 1'b0);
    run_op("sh_hi", 1'b0, 1'b1, 3'b001, 32'h0000_5006, 32'h9999_BEEF, 32'h0, 1, 0, 1'b1);
    run_op("nop",   1'b0, 1'b0, 3'b010, 32'h0000_6000, 32'h0,         32'h0, 0, 0, 1'b1);
    run_op("spur",  1'b1, 1'b0, 3'b100, 32'h0000_7003, 32'h0,         32'h5A5A_A5A5, 2, 3, 1'b1);

    // Reset while waiting for a load response; the late response must be ignored
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_func3 = 3'b010; ex_addr = 32'h0000_8000;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rstw.in_wait_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; ex_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    exp_ld_data = '0; exp_ld_lo = 2'b00; exp_ld_f3 = 3'b000;
    #1;
    chk("rstw.stall",     32'(stall),         32'd0);
    chk("rstw.req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("rstw.ld_valid",  32'(ld_valid),      32'd0);
    chk("rstw.fault",     32'(fault),         32'd0);
    chk("rstw.req_addr",  mem_req_addr,       32'd0);
    chk("rstw.req_we",    32'(mem_req_we),    32'd0);
    chk("rstw.req_mask",  32'(mem_req_wmask), 32'd0);
    chk("rstw.req_wdata", mem_req_wdata,      32'd0);
    check_ld_hold("rstw");

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      bit          ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          pick = int'($urandom_range(0, 19));
      ld = ($urandom % 2) == 1;
      st = !ld;
      if (pick == 0) begin ld = 1'b1; st = 1'b1; end
      if (pick == 1) begin ld = 1'b0; st = 1'b0; end
      f3 = 3'($urandom);
      a  = $urandom;
      if (($urandom % 10) < 6) a = a & ~((32'd1 << int'(f3[1:0])) - 32'd1);
      run_op("rnd", ld, st, f3, a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage of the RV32 pipeline.
- Takes load/store operations from execute and issues word-aligned requests to the data cache over a valid/ready handshake.
- Generates store byte lanes and stalls the pipeline until each access completes.
- For loads, registers the raw 32-bit response together with addr[1:0] and func3; this triple feeds the downstream load sign/zero-extend mask.

Parameters:
WIDTH, 32, data width in bits (only 32 supported)
ADDR_W, 32, byte address width

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
ex_valid  input  1  execute stage presents an instruction
ex_load  input  1  instruction is a load
ex_store  input  1  instruction is a store
ex_func3  input  3  RISC-V funct3 (size/signedness)
ex_addr  input  ADDR_W  effective byte address
ex_wdata  input  WIDTH  store data, unaligned (rs2)
stall  output  1  hold execute stage and upstream
mem_req_valid  output  1  request valid
mem_req_ready  input  1  cache accepts request
mem_req_addr  output  ADDR_W  {addr[ADDR_W-1:2],2'b00}
mem_req_we  output  1  1 = store
mem_req_wmask  output  4  byte-lane write enables
mem_req_wdata  output  WIDTH  lane-replicated store data
mem_resp_valid  input  1  load data valid (one cycle)
mem_resp_data  input  WIDTH  raw load word
ld_valid  output  1  one-cycle pulse: load result available
ld_addr_lo  output  2  latched addr[1:0] of the load
ld_func3  output  3  latched funct3 of the load
ld_data  output  WIDTH  latched raw response word
fault  output  1  one-cycle pulse: misaligned or illegal access

Behaviour:
- Reset, while reset_n=0 at a clock edge:
  - state=IDLE.
  - mem_req_valid, ld_valid and fault are 0.
  - ld_addr_lo, ld_func3 and ld_data are 0.
  - Request registers are 0.
  - Reset mid-access abandons the operation; any later mem_resp_valid is ignored.
- Operation present: op = ex_valid & (ex_load | ex_store).
- Fault conditions:
  - ex_load & ex_store both set.
  - func3[1:0]=2'b11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - op & fault: no request issued. fault=1 on the next cycle. stall=0, so the op is dropped. Stay in IDLE.
  - op & legal: latch addr, func3, wmask, wdata and we; go to REQ. stall=1 combinationally this cycle.
- REQ:
  - mem_req_valid=1. All mem_req_* outputs are held stable until mem_req_ready=1.
  - Store handshake: stall=0 in that cycle; next state IDLE. This is the completion cycle.
  - Load handshake: next state WAIT; stall=1.
  - No handshake: stall=1.
- WAIT:
  - mem_req_valid=0.
  - While mem_resp_valid=0: stall=1.
  - When mem_resp_valid=1: stall=0 in that cycle (completion). At the edge, capture ld_data=mem_resp_data, ld_addr_lo and ld_func3 from the latched op. Go to IDLE.
  - ld_valid=1 for exactly the following cycle.
- mem_resp_valid outside WAIT is ignored.
- The cache guarantees at least one cycle between the load handshake and the response.
- stall = (state!=IDLE & !completion) | (state==IDLE & op & !fault).
- Back-to-back ops: minimum 2 cycles per store and 3 per load with zero-wait memory. A new op is sampled in the IDLE cycle after completion.
- Store lanes:
  - SB (func3[1:0]=00): wmask = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH (01): wmask = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW (10): wmask = 4'b1111; wdata unchanged.
- Loads: we=0, wmask=4'b0000, wdata=0.
- ld_* outputs hold their last value until the next load completes. Only ld_valid pulses.

Test Plan:
- Reset then SB, addr=0x1003, wdata=0xAABBCCDD, ready=1 -> REQ cycle shows req_addr=0x1000, wmask=4'b1000, wdata=0xDDDDDDDD, we=1; stall high 1 cycle then low at handshake; state IDLE after.
- LHU, addr=0x2002, ready held 0 for 3 cycles, response 0x8765_4321 two cycles after handshake -> req fields stable during wait; stall high throughout; ld_valid pulse with ld_data=0x87654321, ld_addr_lo=2, ld_func3=3'b101.
- LW at addr=0x3001 -> no mem_req_valid; fault=1 one cycle; stall never asserted. Repeat with func3=3'b011 -> fault.
- Back-to-back SW 0x4000 then LB 0x4005 with zero-wait cache -> SW wmask=4'b1111; LB issued at 0x4004; exactly one ld_valid; ld_addr_lo=1.
- reset_n=0 while in WAIT, then mem_resp_valid=1 after release -> no ld_valid, stall=0, all outputs at reset values.
- Spurious mem_resp_valid while IDLE or REQ -> ld_valid stays 0, ld_data unchanged.
